// File: rtl/cpu_muldiv_sequencer_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
package cpu_muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } muldiv_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StWait,
    StSpecial,
    StDone
  } seq_state_t;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam int unsigned CntWidth = 6;

  function automatic logic op1_is_signed(muldiv_op_t op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic op2_is_signed(muldiv_op_t op);
    return op inside {OpMul, OpMulh, OpDiv, OpRem};
  endfunction

  function automatic logic [31:0] select_result(muldiv_op_t op, logic [63:0] product,
                                                logic [31:0] quotient, logic [31:0] remainder);
    logic [31:0] res;
    case (op)
      OpMul:                     res = product[31:0];
      OpMulh, OpMulhsu, OpMulhu: res = product[63:32];
      OpDiv, OpDivu:             res = quotient;
      default:                   res = remainder;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_muldiv_special.sv
// Combinational detection of divide-by-zero and signed-overflow divides and their results.
module cpu_muldiv_special
  import cpu_muldiv_sequencer_pkg::*;
(
  input  muldiv_op_t  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_is_special,
  output logic [31:0] o_special_result
);

  logic is_div;
  logic is_rem;
  logic div_zero;
  logic overflow;

  always_comb begin
    is_div           = i_op[2];
    is_rem           = i_op inside {OpRem, OpRemu};
    div_zero         = is_div && (i_rs2 == '0);
    overflow         = (i_op inside {OpDiv, OpRem}) && (i_rs1 == INT_MIN) && (i_rs2 == ALL_ONES);
    o_is_special     = div_zero || overflow;
    o_special_result = '0;
    if (div_zero) begin
      o_special_result = is_rem ? i_rs1 : ALL_ONES;
    end else if (overflow) begin
      o_special_result = is_rem ? 32'h0 : INT_MIN;
    end
  end

endmodule

// File: rtl/cpu_muldiv_sequencer.sv
// Sequencer for the shared RV32M multiplier/divider datapaths.
// Optional result reuse cache enabled by defining CPU_MULDIV_REUSE_EN.
module cpu_muldiv_sequencer
  import cpu_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned DIV_LATENCY = 32,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_request,
  input  logic [2:0]           i_op,
  input  logic [31:0]          i_rs1,
  input  logic [31:0]          i_rs2,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic                 i_flush,
  output logic                 o_busy,
  output logic                 o_mul_latch,
  output logic                 o_div_latch,
  output logic                 o_op1_signed,
  output logic                 o_op2_signed,
  output logic [31:0]          o_op1,
  output logic [31:0]          o_op2,
  input  logic [63:0]          i_mul_result,
  input  logic [31:0]          i_div_quotient,
  input  logic [31:0]          i_div_remainder,
  output logic                 o_valid,
  output logic [31:0]          o_result,
  output logic [TAG_WIDTH-1:0] o_tag
);

  seq_state_t           state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  muldiv_op_t           op_q;
  logic [31:0]          op1_q, op2_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 op1_signed_q, op2_signed_q;
  logic [31:0]          result_q;
  logic [TAG_WIDTH-1:0] out_tag_q;

  logic        can_accept;
  logic        accept;
  logic        wait_done;
  muldiv_op_t  chk_op;
  logic [31:0] chk_rs1, chk_rs2;
  logic        is_special;
  logic [31:0] special_result;
  logic        reuse_hit;
  logic [31:0] reuse_result;

  assign can_accept = (state_q == StIdle) || (state_q == StDone);
  assign accept     = i_request && can_accept && !i_flush;
  assign wait_done  = (state_q == StWait) && (cnt_q == '0) && !i_flush;

  // Special/reuse decisions use the raw request when accepting, the latched copy in SPECIAL.
  always_comb begin
    if (can_accept) begin
      chk_op  = muldiv_op_t'(i_op);
      chk_rs1 = i_rs1;
      chk_rs2 = i_rs2;
    end else begin
      chk_op  = op_q;
      chk_rs1 = op1_q;
      chk_rs2 = op2_q;
    end
  end

  cpu_muldiv_special u_special (
    .i_op             (chk_op),
    .i_rs1            (chk_rs1),
    .i_rs2            (chk_rs2),
    .o_is_special     (is_special),
    .o_special_result (special_result)
  );

`ifdef CPU_MULDIV_REUSE_EN
  logic        mul_vld_q, div_vld_q;
  logic [31:0] mul_a_q, mul_b_q, div_a_q, div_b_q;
  logic        mul_sa_q, mul_sb_q, div_sa_q, div_sb_q;
  logic [63:0] mul_prod_q;
  logic [31:0] div_quot_q, div_rem_q;
  logic        mul_hit, div_hit;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      mul_vld_q  <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_sa_q   <= 1'b0;
      mul_sb_q   <= 1'b0;
      mul_prod_q <= '0;
      div_vld_q  <= 1'b0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      div_sa_q   <= 1'b0;
      div_sb_q   <= 1'b0;
      div_quot_q <= '0;
      div_rem_q  <= '0;
    end else if (i_flush) begin
      mul_vld_q <= 1'b0;
      div_vld_q <= 1'b0;
    end else if (wait_done) begin
      if (!op_q[2]) begin
        mul_vld_q  <= 1'b1;
        mul_a_q    <= op1_q;
        mul_b_q    <= op2_q;
        mul_sa_q   <= op1_signed_q;
        mul_sb_q   <= op2_signed_q;
        mul_prod_q <= i_mul_result;
      end else begin
        div_vld_q  <= 1'b1;
        div_a_q    <= op1_q;
        div_b_q    <= op2_q;
        div_sa_q   <= op1_signed_q;
        div_sb_q   <= op2_signed_q;
        div_quot_q <= i_div_quotient;
        div_rem_q  <= i_div_remainder;
      end
    end
  end

  // The low product word does not depend on signedness, so MUL hits any entry.
  always_comb begin
    mul_hit = !chk_op[2] && mul_vld_q && (mul_a_q == chk_rs1) && (mul_b_q == chk_rs2) &&
              ((chk_op == OpMul) ||
               ((mul_sa_q == op1_is_signed(chk_op)) && (mul_sb_q == op2_is_signed(chk_op))));
    div_hit = chk_op[2] && div_vld_q && (div_a_q == chk_rs1) && (div_b_q == chk_rs2) &&
              (div_sa_q == op1_is_signed(chk_op)) && (div_sb_q == op2_is_signed(chk_op));
    reuse_hit    = mul_hit || div_hit;
    reuse_result = select_result(chk_op, mul_prod_q, div_quot_q, div_rem_q);
  end
`else
  assign reuse_hit    = 1'b0;
  assign reuse_result = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = (is_special || reuse_hit) ? StSpecial : StLatch;
        end else begin
          state_d = StIdle;
        end
      end
      StLatch: begin
        cnt_d   = op_q[2] ? CntWidth'(DIV_LATENCY - 1) : CntWidth'(MUL_LATENCY - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSpecial: state_d = StDone;
      default:   state_d = StIdle;
    endcase
    if (i_flush && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_q         <= OpMul;
      op1_q        <= '0;
      op2_q        <= '0;
      tag_q        <= '0;
      op1_signed_q <= 1'b0;
      op2_signed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q         <= muldiv_op_t'(i_op);
        op1_q        <= i_rs1;
        op2_q        <= i_rs2;
        tag_q        <= i_tag;
        op1_signed_q <= op1_is_signed(muldiv_op_t'(i_op));
        op2_signed_q <= op2_is_signed(muldiv_op_t'(i_op));
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      result_q  <= '0;
      out_tag_q <= '0;
    end else if (wait_done) begin
      result_q  <= select_result(op_q, i_mul_result, i_div_quotient, i_div_remainder);
      out_tag_q <= tag_q;
    end else if ((state_q == StSpecial) && !i_flush) begin
      result_q  <= is_special ? special_result : reuse_result;
      out_tag_q <= tag_q;
    end
  end

  assign o_busy       = !can_accept;
  assign o_valid      = (state_q == StDone);
  assign o_mul_latch  = (state_q == StLatch) && !i_flush && !op_q[2];
  assign o_div_latch  = (state_q == StLatch) && !i_flush && op_q[2];
  assign o_op1        = op1_q;
  assign o_op2        = op2_q;
  assign o_op1_signed = op1_signed_q;
  assign o_op2_signed = op2_signed_q;
  assign o_result     = result_q;
  assign o_tag        = out_tag_q;

endmodule

// File: tb/tb_cpu_muldiv_sequencer.sv
// Self-checking bench for cpu_muldiv_sequencer with behavioural multiplier/divider models.
module tb_cpu_muldiv_sequencer;

  localparam int unsigned MulLat = 4;
  localparam int unsigned DivLat = 32;
  localparam int unsigned TagW   = 4;

  logic            i_clock = 1'b0;
  logic            i_reset = 1'b0;
  logic            i_request = 1'b0;
  logic [2:0]      i_op = '0;
  logic [31:0]     i_rs1 = '0;
  logic [31:0]     i_rs2 = '0;
  logic [TagW-1:0] i_tag = '0;
  logic            i_flush = 1'b0;
  logic            o_busy, o_mul_latch, o_div_latch, o_op1_signed, o_op2_signed;
  logic [31:0]     o_op1, o_op2;
  logic [63:0]     i_mul_result;
  logic [31:0]     i_div_quotient, i_div_remainder;
  logic            o_valid;
  logic [31:0]     o_result;
  logic [TagW-1:0] o_tag;

  always #5 i_clock = ~i_clock;

  cpu_muldiv_sequencer #(
    .MUL_LATENCY (MulLat),
    .DIV_LATENCY (DivLat),
    .TAG_WIDTH   (TagW)
  ) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_request       (i_request),
    .i_op            (i_op),
    .i_rs1           (i_rs1),
    .i_rs2           (i_rs2),
    .i_tag           (i_tag),
    .i_flush         (i_flush),
    .o_busy          (o_busy),
    .o_mul_latch     (o_mul_latch),
    .o_div_latch     (o_div_latch),
    .o_op1_signed    (o_op1_signed),
    .o_op2_signed    (o_op2_signed),
    .o_op1           (o_op1),
    .o_op2           (o_op2),
    .i_mul_result    (i_mul_result),
    .i_div_quotient  (i_div_quotient),
    .i_div_remainder (i_div_remainder),
    .o_valid         (o_valid),
    .o_result        (o_result),
    .o_tag           (o_tag)
  );

  typedef struct {
    logic [31:0]     result;
    logic [TagW-1:0] tag;
  } exp_t;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  // Datapath models: outputs are garbage until their latency has elapsed.
  logic [63:0] mul_prod = '0;
  int          mul_cnt = -1;
  logic [31:0] div_quot = '0, div_rem = '0;
  int          div_cnt = -1;

  function automatic logic [63:0] ext(logic [31:0] v, logic s);
    return {{32{s & v[31]}}, v};
  endfunction

  always @(posedge i_clock) begin
    if (o_mul_latch) begin
      mul_prod <= ext(o_op1, o_op1_signed) * ext(o_op2, o_op2_signed);
      mul_cnt  <= MulLat - 1;
    end else if (mul_cnt > 0) begin
      mul_cnt <= mul_cnt - 1;
    end
  end

  always @(posedge i_clock) begin
    if (o_div_latch) begin
      int sa, sd;
      sa = $signed(o_op1);
      sd = $signed(o_op2);
      if (o_op2 == 32'h0) begin
        div_quot <= 32'hFFFF_FFFF;
        div_rem  <= o_op1;
      end else if (o_op1_signed && !(o_op1 == 32'h8000_0000 && o_op2 == 32'hFFFF_FFFF)) begin
        div_quot <= 32'(sa / sd);
        div_rem  <= 32'(sa % sd);
      end else if (o_op1_signed) begin
        div_quot <= 32'h8000_0000;
        div_rem  <= 32'h0;
      end else begin
        div_quot <= o_op1 / o_op2;
        div_rem  <= o_op1 % o_op2;
      end
      div_cnt <= DivLat - 1;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
    end
  end

  assign i_mul_result    = (mul_cnt == 0) ? mul_prod : 64'hDEAD_BEEF_0BAD_F00D;
  assign i_div_quotient  = (div_cnt == 0) ? div_quot : 32'hBAAD_F00D;
  assign i_div_remainder = (div_cnt == 0) ? div_rem : 32'hF00D_BAAD;

  always @(negedge i_clock) begin
    if (i_reset && o_valid) begin
      checks++;
      if (scoreboard.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got valid with result %h tag %0d, required no valid",
                 o_result, o_tag);
      end else begin
        exp_t e;
        e = scoreboard.pop_front();
        if (o_result !== e.result || o_tag !== e.tag) begin
          errors++;
          $display("FAIL result: got %h tag %0d, required %h tag %0d",
                   o_result, o_tag, e.result, e.tag);
        end
      end
    end
  end

  // Called at a negedge; leaves the caller at the negedge of the cycle after acceptance.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TagW-1:0] tag);
    i_request = 1'b1;
    i_op      = op;
    i_rs1     = a;
    i_rs2     = b;
    i_tag     = tag;
    @(negedge i_clock);
    i_request = 1'b0;
  endtask

  task automatic push(input logic [31:0] r, input logic [TagW-1:0] t);
    exp_t e;
    e.result = r;
    e.tag    = t;
    scoreboard.push_back(e);
  endtask

  task automatic wait_valid(input int start, output int n);
    n = start;
    while (!o_valid && n < 200) begin
      @(negedge i_clock);
      n++;
    end
  endtask

  task automatic check_latency(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({o_busy, o_mul_latch, o_div_latch, o_op1_signed, o_op2_signed, o_valid, o_op1, o_op2,
         o_result, o_tag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy %b valid %b op1 %h result %h, required all 0",
               o_busy, o_valid, o_op1, o_result);
    end
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
  endtask

  task automatic test_mul;
    int n;
    push(32'hFFFF_FFEB, 4'd1);
    drive(3'd0, 32'd7, 32'hFFFF_FFFD, 4'd1);
    checks++;
    if ({o_mul_latch, o_div_latch, o_busy, o_op1_signed, o_op2_signed} !== 5'b10111) begin
      errors++;
      $display("FAIL mul_latch: got latch/dlatch/busy/s1/s2 %b, required 10111",
               {o_mul_latch, o_div_latch, o_busy, o_op1_signed, o_op2_signed});
    end
    @(negedge i_clock);
    checks++;
    if (o_mul_latch !== 1'b0) begin
      errors++;
      $display("FAIL mul_latch_pulse: got %b, required 0", o_mul_latch);
    end
    wait_valid(2, n);
    check_latency("mul", n, MulLat + 2);
    @(negedge i_clock);
  endtask

  task automatic test_mulh_variants;
    int n;
    push(32'hFFFF_FFFE, 4'd2);
    drive(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
    wait_valid(1, n);
    @(negedge i_clock);
    push(32'hFFFF_FFFF, 4'd3);
    drive(3'd2, 32'hFFFF_FFFF, 32'd2, 4'd3);
    checks++;
    if ({o_op1_signed, o_op2_signed} !== 2'b10) begin
      errors++;
      $display("FAIL mulhsu_signedness: got %b, required 10", {o_op1_signed, o_op2_signed});
    end
    wait_valid(1, n);
    check_latency("mulhsu", n, MulLat + 2);
    @(negedge i_clock);
    push(32'h4000_0000, 4'd4);
    drive(3'd1, 32'h8000_0000, 32'h8000_0000, 4'd4);
    wait_valid(1, n);
    @(negedge i_clock);
  endtask

  task automatic test_special;
    int n;
    push(32'h8000_0000, 4'd7);
    drive(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7);
    checks++;
    if ({o_div_latch, o_mul_latch, o_busy} !== 3'b001) begin
      errors++;
      $display("FAIL special_no_latch: got dlatch/mlatch/busy %b, required 001",
               {o_div_latch, o_mul_latch, o_busy});
    end
    wait_valid(1, n);
    check_latency("div_overflow", n, 2);
    @(negedge i_clock);
    push(32'h0, 4'd8);
    drive(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8);
    wait_valid(1, n);
    check_latency("rem_overflow", n, 2);
    @(negedge i_clock);
    push(32'hFFFF_FFFF, 4'd9);
    drive(3'd5, 32'd55, 32'd0, 4'd9);
    wait_valid(1, n);
    check_latency("divu_zero", n, 2);
    @(negedge i_clock);
    push(32'd13, 4'd10);
    drive(3'd6, 32'd13, 32'd0, 4'd10);
    wait_valid(1, n);
    @(negedge i_clock);
  endtask

  task automatic test_back_to_back;
    int n;
    push(32'd14, 4'd5);
    drive(3'd4, 32'd100, 32'd7, 4'd5);
    wait_valid(1, n);
    check_latency("div", n, DivLat + 2);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL done_busy: got %b, required 0", o_busy);
    end
    push(32'd2, 4'd6);
    drive(3'd7, 32'd100, 32'd7, 4'd6);
    wait_valid(1, n);
    check_latency("remu_b2b", n, DivLat + 2);
    push(32'hFFFF_FFF2, 4'd11);
    drive(3'd4, 32'hFFFF_FF9C, 32'd7, 4'd11);
    wait_valid(1, n);
    push(32'hFFFF_FFFE, 4'd12);
    drive(3'd6, 32'hFFFF_FF9C, 32'd7, 4'd12);
    wait_valid(1, n);
    repeat (3) @(negedge i_clock);
    checks++;
    if (o_result !== 32'hFFFF_FFFE || o_tag !== 4'd12 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL result_hold: got %h tag %0d valid %b, required fffffffe tag 12 valid 0",
               o_result, o_tag, o_valid);
    end
  endtask

  task automatic test_flush;
    int seen;
    drive(3'd4, 32'd50, 32'd3, 4'd3);
    repeat (5) @(negedge i_clock);
    i_flush = 1'b1;
    @(negedge i_clock);
    i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: got %b, required 0", o_busy);
    end
    drive(3'd4, 32'd60, 32'd4, 4'd2);
    repeat (3) @(negedge i_clock);
    i_flush   = 1'b1;
    i_request = 1'b1;
    i_op      = 3'd0;
    i_rs1     = 32'd3;
    i_rs2     = 32'd3;
    @(negedge i_clock);
    i_request = 1'b0;
    i_flush   = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_mul_latch !== 1'b0) begin
      errors++;
      $display("FAIL flush_request: got busy %b latch %b, required 0 0", o_busy, o_mul_latch);
    end
    drive(3'd0, 32'd5, 32'd5, 4'd1);
    i_flush = 1'b1;
    #1;
    checks++;
    if (o_mul_latch !== 1'b0) begin
      errors++;
      $display("FAIL flush_latch: got %b, required 0", o_mul_latch);
    end
    @(negedge i_clock);
    i_flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge i_clock);
      if (o_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_no_valid: got %0d valid pulses, required 0", seen);
    end
  endtask

  task automatic test_async_reset;
    int n;
    drive(3'd4, 32'd9, 32'd2, 4'd4);
    repeat (5) @(negedge i_clock);
    #2 i_reset = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_mul_latch, o_div_latch, o_op1_signed, o_op2_signed, o_valid, o_op1, o_op2,
         o_result, o_tag} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy %b op1 %h result %h tag %0d, required all 0",
               o_busy, o_op1, o_result, o_tag);
    end
    @(negedge i_clock);
    i_reset = 1'b1;
    scoreboard.delete();
    @(negedge i_clock);
    push(32'd12, 4'd9);
    drive(3'd0, 32'd3, 32'd4, 4'd9);
    wait_valid(1, n);
    check_latency("mul_after_reset", n, MulLat + 2);
    @(negedge i_clock);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh_variants();
    test_special();
    test_back_to_back();
    test_flush();
    test_async_reset();
    repeat (2) @(negedge i_clock);
    checks++;
    if (scoreboard.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", scoreboard.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
